// File: rtl/accum_driver.sv
`default_nettype none
// ============================================================================
// Module      : accum_driver
// Description : Sequences one command at a time into an external 4-bit
//               accumulator ALU. It waits a fixed latency, captures the ALU
//               result into a first-word-fall-through result FIFO, and
//               optionally checks the result against a built-in model.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   LATENCY    : cycles from alu_* operand drive to alu_r/alu_of sampling
//                (1..7)
//   FIFO_DEPTH : result FIFO entries (power of two, 2..16)
// Ports
//   Clk, Reset                      : clock and synchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_a, cmd_b, cmd_m, cmd_cin    : command operands and mode
//   alu_a, alu_b, alu_m, alu_cin    : operands held towards the ALU
//   alu_r, alu_of                   : ALU result and overflow
//   res_valid/res_ready             : result handshake (FIFO head)
//   res_r, res_of, res_m            : result, overflow and mode tag
//   busy                            : a command is in flight
//   err_flag, err_count             : checker status (sticky flag,
//                                     saturating count)
// Build option
//   ACCUM_DRIVER_CHECK_EN : when defined, the expected-result checker is
//                           built. Otherwise err_flag/err_count are tied to 0.
// ============================================================================
module accum_driver #(
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_m,
  input  logic       cmd_cin,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_m,
  output logic       alu_cin,
  input  logic [3:0] alu_r,
  input  logic       alu_of,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_r,
  output logic       res_of,
  output logic [3:0] res_m,
  output logic       busy,
  output logic       err_flag,
  output logic [7:0] err_count
);

  localparam int                c_PW       = $clog2(FIFO_DEPTH);
  localparam int                c_CW       = c_PW + 1;
  localparam logic [c_CW-1:0]   c_DEPTH    = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0]   c_CNT_ONE  = c_CW'(1);
  localparam logic [c_PW-1:0]   c_PTR_ONE  = c_PW'(1);
  localparam logic [2:0]        c_LAT      = 3'(LATENCY);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT    = 2'd1;
  localparam logic [1:0] c_CAPTURE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      alu_a_q, alu_b_q, alu_m_q;
  logic            alu_cin_q;
  logic [c_PW-1:0] wr_q, rd_q;
  logic [c_CW-1:0] count_q;
  logic [8:0]      mem_q [FIFO_DEPTH];

  logic w_accept;
  logic w_push;
  logic w_pop;

  // Acceptance needs IDLE (so only one command is ever in flight) and a
  // free FIFO slot, which together guarantee the later push always fits.
  assign cmd_ready = !Reset && (state_q == c_IDLE) && (count_q < c_DEPTH);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_push    = (state_q == c_CAPTURE);
  assign w_pop     = (count_q != '0) && res_ready;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (w_accept) begin
          state_d = c_WAIT;
          cnt_d   = c_LAT;
        end
      end
      c_WAIT: begin
        if (cnt_q == 3'd1) begin
          state_d = c_CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      c_CAPTURE: state_d = c_IDLE;
      default:   state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= c_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operands only load on acceptance, which can only happen in IDLE, so
  // they stay stable through WAIT and CAPTURE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      alu_a_q   <= 4'd0;
      alu_b_q   <= 4'd0;
      alu_m_q   <= 4'd0;
      alu_cin_q <= 1'b0;
    end else if (w_accept) begin
      alu_a_q   <= cmd_a;
      alu_b_q   <= cmd_b;
      alu_m_q   <= cmd_m;
      alu_cin_q <= cmd_cin;
    end
  end

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_m   = alu_m_q;
  assign alu_cin = alu_cin_q;
  assign busy    = (state_q != c_IDLE);

  // --------------------------------------------------------- result FIFO
  // Pointers are exactly log2(depth) bits wide, so they wrap naturally.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + c_PTR_ONE;
      if (w_pop)  rd_q <= rd_q + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_CNT_ONE;
        2'b01:   count_q <= count_q - c_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset && w_push) begin
      mem_q[wr_q] <= {alu_r, alu_of, alu_m_q};
    end
  end

  assign res_valid = (count_q != '0);
  assign {res_r, res_of, res_m} = mem_q[rd_q];

  // ------------------------------------------------------------ checker
`ifdef ACCUM_DRIVER_CHECK_EN
  logic [3:0] w_exp_r;
  logic       w_chk;
  logic       err_flag_q;
  logic [7:0] err_count_q;

  always_comb begin
    w_exp_r = 4'd0;
    w_chk   = 1'b1;
    case (alu_m_q)
      4'b0000: w_exp_r = alu_a_q + alu_b_q + {3'd0, alu_cin_q};
      4'b0001: w_exp_r = alu_a_q - alu_b_q;
      4'b0011: w_exp_r = alu_a_q & alu_b_q;
      4'b0100: w_exp_r = alu_a_q | alu_b_q;
      4'b0101: w_exp_r = ~alu_a_q;
      4'b0110: w_exp_r = alu_a_q + 4'd1;
      4'b0111: w_exp_r = alu_a_q - 4'd1;
      default: w_chk   = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      err_flag_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else if (w_push && w_chk && (alu_r != w_exp_r)) begin
      err_flag_q <= 1'b1;
      if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
`else
  assign err_flag  = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_accum_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_driver
// Description : Self-checking bench for accum_driver. Two instances
//               (LATENCY=1/FIFO_DEPTH=4 and LATENCY=3/FIFO_DEPTH=2) share
//               stimulus. A behavioural ALU answers each instance, and a
//               queue-style reference model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_driver;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, cmd_valid, cmd_cin, res_ready, inj;
  logic [3:0] cmd_a, cmd_b, cmd_m;

  logic       cmd_ready [2];
  logic       alu_cin   [2];
  logic       alu_of    [2];
  logic       res_valid [2];
  logic       res_of    [2];
  logic       busy      [2];
  logic       err_flag  [2];
  logic [3:0] alu_a     [2];
  logic [3:0] alu_b     [2];
  logic [3:0] alu_m     [2];
  logic [3:0] alu_r     [2];
  logic [3:0] res_r     [2];
  logic [3:0] res_m     [2];
  logic [7:0] err_count [2];

  accum_driver #(.LATENCY(1), .FIFO_DEPTH(4)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_m(cmd_m), .cmd_cin(cmd_cin),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_m(alu_m[0]), .alu_cin(alu_cin[0]),
    .alu_r(alu_r[0]), .alu_of(alu_of[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready), .res_r(res_r[0]),
    .res_of(res_of[0]), .res_m(res_m[0]), .busy(busy[0]),
    .err_flag(err_flag[0]), .err_count(err_count[0])
  );

  accum_driver #(.LATENCY(3), .FIFO_DEPTH(2)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_m(cmd_m), .cmd_cin(cmd_cin),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_m(alu_m[1]), .alu_cin(alu_cin[1]),
    .alu_r(alu_r[1]), .alu_of(alu_of[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready), .res_r(res_r[1]),
    .res_of(res_of[1]), .res_m(res_m[1]), .busy(busy[1]),
    .err_flag(err_flag[1]), .err_count(err_count[1])
  );

  // Arithmetic meaning of each mode; unlisted modes get an arbitrary mix.
  function automatic logic [3:0] gold_r(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] m, input logic cin);
    case (m)
      4'd0:    return a + b + {3'd0, cin};
      4'd1:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return ~a;
      4'd6:    return a + 4'd1;
      4'd7:    return a - 4'd1;
      default: return a ^ b ^ m;
    endcase
  endfunction

  function automatic logic is_checked(input logic [3:0] m);
    return (m inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7});
  endfunction

  // External ALU: correct result, or bit 0 flipped while inj is set.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] m, input logic cin,
                                           input logic bad);
    logic [3:0] r;
    logic       of;
    r  = gold_r(a, b, m, cin) ^ {3'd0, bad};
    of = (m == 4'd0) ? ((5'(a) + 5'(b) + 5'(cin)) > 5'd15) : 1'b0;
    return {r, of};
  endfunction

  assign {alu_r[0], alu_of[0]} = alu_model(alu_a[0], alu_b[0], alu_m[0], alu_cin[0], inj);
  assign {alu_r[1], alu_of[1]} = alu_model(alu_a[1], alu_b[1], alu_m[1], alu_cin[1], inj);

  // ------------------------------------------------------ reference model
  int          lat_k [2] = '{1, 3};
  int          dep_k [2] = '{4, 2};
  logic [8:0]  mfifo [2][16];
  int          mhead [2];
  int          mcnt  [2];
  int          mtmr  [2];
  bit          minf  [2];
  logic [12:0] mop   [2];
  bit          mef   [2];
  int          mec   [2];

  bit          s_acc [2];
  bit          s_pop [2];
  bit          s_rst;
  logic [12:0] s_cmd;
  logic [3:0]  pop_log [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    logic [3:0] a, b, m, r;
    logic       c;
    logic [4:0] res;
    if (s_rst) begin
      minf[k] = 0; mcnt[k] = 0; mhead[k] = 0; mef[k] = 0; mec[k] = 0;
    end else begin
      if (s_pop[k]) begin
        mhead[k] = (mhead[k] + 1) % dep_k[k];
        mcnt[k]--;
      end
      if (minf[k]) begin
        mtmr[k]--;
        if (mtmr[k] == 0) begin
          {a, b, m, c} = mop[k];
          res = alu_model(a, b, m, c, inj);
          r   = res[4:1];
          mfifo[k][(mhead[k] + mcnt[k]) % dep_k[k]] = {r, res[0], m};
          mcnt[k]++;
          minf[k] = 0;
          if (is_checked(m) && r != gold_r(a, b, m, c)) begin
            mef[k] = 1;
            if (mec[k] < 255) mec[k]++;
          end
        end
      end
      // Result lands LATENCY+1 edges after the acceptance edge.
      if (s_acc[k]) begin
        minf[k] = 1;
        mtmr[k] = lat_k[k] + 1;
        mop[k]  = s_cmd;
      end
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the
  // rising edge, return 1 time unit later so callers drive new inputs.
  task automatic cycle();
    bit rdy;
    @(negedge Clk);
    s_rst = Reset;
    s_cmd = {cmd_a, cmd_b, cmd_m, cmd_cin};
    for (int k = 0; k < 2; k++) begin
      rdy = !Reset && !minf[k] && (mcnt[k] < dep_k[k]);
      chk($sformatf("cmd_ready%0d", k), cmd_ready[k], rdy);
      chk($sformatf("res_valid%0d", k), res_valid[k], mcnt[k] > 0);
      chk($sformatf("busy%0d", k), busy[k], minf[k]);
      if (mcnt[k] > 0)
        chk($sformatf("res_head%0d", k), {res_r[k], res_of[k], res_m[k]}, mfifo[k][mhead[k]]);
      if (minf[k])
        chk($sformatf("alu_ops%0d", k), {alu_a[k], alu_b[k], alu_m[k], alu_cin[k]}, mop[k]);
`ifdef ACCUM_DRIVER_CHECK_EN
      chk($sformatf("err_flag%0d", k), err_flag[k], mef[k]);
      chk($sformatf("err_count%0d", k), err_count[k], 16'(mec[k]));
`else
      chk($sformatf("err_flag%0d", k), err_flag[k], 1'b0);
      chk($sformatf("err_count%0d", k), err_count[k], 8'd0);
`endif
      s_acc[k] = cmd_valid && rdy;
      s_pop[k] = (mcnt[k] > 0) && res_ready;
    end
    if (res_valid[0] && res_ready && !Reset) pop_log.push_back(res_r[0]);
    @(posedge Clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] m, input logic c);
    int t;
    cmd_a = a; cmd_b = b; cmd_m = m; cmd_cin = c; cmd_valid = 1'b1;
    t = 0;
    do begin
      cycle();
      t++;
    end while (!s_acc[0] && t < 100);
    chk("send_accepted", s_acc[0], 1'b1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (minf[0] && t < 100) begin
      cycle();
      t++;
    end
    chk("idle_reached", busy[0], 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycle();
    chk("rst_res_valid", res_valid[0], 1'b0);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_cmd_ready", cmd_ready[0], 1'b0);
    Reset = 1'b0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_q [$];
    Reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_m = '0;
    cmd_cin = 1'b0; res_ready = 1'b0; inj = 1'b0;

    // Reset state.
    @(posedge Clk);
    @(posedge Clk);
    #1;
    chk("reset_cmd_ready", cmd_ready[0], 1'b0);
    chk("reset_res_valid", res_valid[0], 1'b0);
    chk("reset_busy", busy[0], 1'b0);
    chk("reset_alu", {alu_a[0], alu_b[0], alu_m[0], alu_cin[0]}, 13'd0);
    chk("reset_alu1", {alu_a[1], alu_b[1], alu_m[1], alu_cin[1]}, 13'd0);
    chk("reset_err", {err_flag[0], err_count[0]}, 9'd0);
    Reset = 1'b0;
    cycle();
    chk("ready_after_reset", cmd_ready[0], 1'b1);

    // Single add, LATENCY=1: result visible 2 cycles after acceptance.
    send(4'b1010, 4'b0101, 4'b0000, 1'b0);
    chk("accept_busy", busy[0], 1'b1);
    chk("accept_alu_a", alu_a[0], 4'b1010);
    chk("accept_alu_b", alu_b[0], 4'b0101);
    chk("lat_rv0", res_valid[0], 1'b0);
    cycle();
    chk("lat_rv1", res_valid[0], 1'b0);
    cycle();
    chk("lat_rv2", res_valid[0], 1'b1);
    chk("add_res_r", res_r[0], 4'b1111);
    chk("add_res_of", res_of[0], 1'b0);
    chk("add_res_m", res_m[0], 4'b0000);

    // Fill the FIFO with res_ready low; one pop re-enables acceptance.
    do_reset();
    res_ready = 1'b0;
    send(4'b0011, 4'b0101, 4'b0000, 1'b0);   // 1000
    send(4'b0110, 4'b0101, 4'b0001, 1'b0);   // 0001
    send(4'b1100, 4'b1010, 4'b0011, 1'b0);   // 1000
    send(4'b1001, 4'b0110, 4'b0100, 1'b0);   // 1111
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("full_cmd_ready", cmd_ready[0], 1'b0);
    end
    chk("full_head", res_r[0], 4'b1000);
    cmd_a = 4'b0001; cmd_b = 4'b0001; cmd_m = 4'b0110; cmd_cin = 1'b0;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    chk("after_pop_head", res_r[0], 4'b0001);
    chk("after_pop_ready", cmd_ready[0], 1'b1);
    send(4'b0001, 4'b0001, 4'b0110, 1'b0);
    wait_idle();

    // Back-to-back with res_ready held: results come out in issue order.
    do_reset();
    res_ready = 1'b1;
    pop_log.delete();
    for (int i = 0; i < 6; i++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      exp_q.push_back(gold_r(a, b, 4'(i), 1'b1));
      send(a, b, 4'(i), 1'b1);
    end
    wait_idle();
    repeat (3) cycle();
    chk("order_count", 16'(pop_log.size()), 16'd6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++)
      chk($sformatf("order_%0d", i), pop_log[i], exp_q[i]);

    // Reset in WAIT with two queued results.
    do_reset();
    res_ready = 1'b0;
    send(4'd1, 4'd2, 4'd0, 1'b0);
    send(4'd3, 4'd4, 4'd0, 1'b0);
    send(4'd5, 4'd6, 4'd0, 1'b0);
    chk("abort_in_wait", busy[0], 1'b1);
    Reset = 1'b1;
    cycle();
    Reset = 1'b0;
    chk("abort_res_valid", res_valid[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("abort_no_push", res_valid[0], 1'b0);
    end

`ifdef ACCUM_DRIVER_CHECK_EN
    // Wrong AND result flagged, then count saturates.
    do_reset();
    res_ready = 1'b1;
    inj = 1'b1;
    send(4'b0111, 4'b1100, 4'b0011, 1'b0);
    wait_idle();
    chk("chk_err_flag", err_flag[0], 1'b1);
    chk("chk_err_count1", err_count[0], 8'd1);
    for (int i = 0; i < 300; i++) send(4'b0111, 4'b1100, 4'b0011, 1'b0);
    wait_idle();
    chk("chk_err_sat", err_count[0], 8'd255);
    chk("chk_err_sticky", err_flag[0], 1'b1);
    inj = 1'b0;
    do_reset();
    chk("chk_err_cleared", {err_flag[0], err_count[0]}, 9'd0);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 4'($urandom_range(0, 15));
      cmd_b     = 4'($urandom_range(0, 15));
      cmd_m     = 4'($urandom_range(0, 15));
      cmd_cin   = 1'($urandom_range(0, 1));
      res_ready = ($urandom_range(0, 3) != 0);
      inj       = ($urandom_range(0, 7) == 0);
      Reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    Reset = 1'b0; cmd_valid = 1'b0; inj = 1'b0;
    repeat (8) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accum_driver.md
ACCUM_DRIVER -- requirements
Module: accum_driver

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from alu_* operand drive to alu_r/alu_of sampling (legal 1..7).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning result FIFO entries (power of two, 2..16).
REQ-003 SHALL have port Clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid  input  1 and cmd_ready  output  1, the command handshake.
REQ-006 SHALL have ports cmd_a, cmd_b, cmd_m  input  4 each and cmd_cin  input  1, the command operands and mode.
REQ-007 SHALL have ports alu_a, alu_b, alu_m  output  4 each and alu_cin  output  1, driven to the accumulator ALU.
REQ-008 SHALL have ports alu_r  input  4 and alu_of  input  1, the ALU result and overflow.
REQ-009 SHALL have ports res_valid  output  1, res_ready  input  1, res_r  output  4, res_of  output  1, res_m  output  4 (mode tag).
REQ-010 SHALL have ports busy  output  1, err_flag  output  1, err_count  output  8.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT, CAPTURE.
REQ-012 SHALL drive cmd_ready = 1 only in IDLE with FIFO occupancy < FIFO_DEPTH.
REQ-013 SHALL, on cmd_valid && cmd_ready, register operands onto alu_* at the next edge and enter WAIT with a counter loaded to LATENCY.
REQ-014 SHALL hold alu_* stable from the acceptance edge until the CAPTURE cycle completes.
REQ-015 SHALL decrement the counter each WAIT cycle and enter CAPTURE when it reaches 1.
REQ-016 SHALL, in CAPTURE, push {alu_r, alu_of, alu_m} into the FIFO and return to IDLE; result push occurs LATENCY+1 cycles after acceptance; max throughput is one command per LATENCY+2 cycles.
REQ-017 SHALL assert busy in WAIT and CAPTURE.
REQ-018 SHALL present the FIFO head on res_r/res_of/res_m (first-word-fall-through), res_valid = occupancy > 0.
REQ-019 SHALL pop on res_valid && res_ready; simultaneous push and pop leaves occupancy unchanged; pop on empty has no effect.
REQ-020 SHALL never overflow the FIFO: acceptance is gated on free space and at most one command is in flight.
REQ-021 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.

Reset
REQ-022 SHALL, while Reset is high at a clock edge, enter IDLE, discard any in-flight command, and empty the FIFO.
REQ-023 SHALL reset alu_a, alu_b, alu_m, alu_cin, res_valid, busy, err_flag, err_count to 0; cmd_ready is 0 during reset and 1 the cycle after.
REQ-024 SHALL treat Reset asserted mid-WAIT or mid-CAPTURE identically: no push occurs in that cycle.

Configuration
REQ-025 SHALL compile an expected-result checker only when macro ACCUM_DRIVER_CHECK_EN is defined.
REQ-026 SHALL, with ACCUM_DRIVER_CHECK_EN, compare alu_r in CAPTURE against a 4-bit model: m=0000 a+b+cin, 0001 a-b, 0011 a&b, 0100 a|b, 0101 ~a, 0110 a+1, 0111 a-1 (all mod 16); other modes unchecked.
REQ-027 SHALL, on mismatch, set err_flag sticky until reset and increment err_count, saturating at 255.
REQ-028 SHALL, without ACCUM_DRIVER_CHECK_EN, tie err_flag and err_count to 0 with no checker logic.

Verification
REQ-029 SHALL cover: LATENCY=1, add a=1010 b=0101 cin=0, ALU model returns r=1111 of=0 -> res_valid 2 cycles after acceptance, res_r=1111, res_of=0, res_m=0000.
REQ-030 SHALL cover: res_ready=0, issue 5 commands with FIFO_DEPTH=4 -> cmd_ready stays 0 after 4th push; popping one entry re-enables acceptance of the 5th.
REQ-031 SHALL cover: res_ready=1 held, back-to-back commands -> simultaneous push/pop keeps occupancy at most 1, results in issue order.
REQ-032 SHALL cover: Reset pulsed during WAIT with 2 entries queued -> res_valid=0, busy=0, no later push of the aborted command.
REQ-033 SHALL cover (ACCUM_DRIVER_CHECK_EN): and a=0111 b=1100, ALU returns 0101 instead of 0100 -> err_flag=1, err_count=1; 300 such errors -> err_count=255.
